// File: rtl/ifmap_mem_fetch.sv
`default_nettype none
// =============================================================================
// Module : ifmap_mem_fetch
// Streams consecutive ifmap lines from memory into a small prefetch FIFO and
// hands them to the decompressor over its mem_req/mem_ack handshake.
// Rev    : 1.0
// =============================================================================
module ifmap_mem_fetch #(
   parameter int MEM_BANDWIDTH = 32,
   parameter int MEM_ADDR_SIZE = 32,
   parameter int FIFO_DEPTH    = 2,
   parameter int LEN_W         = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   input  logic [MEM_ADDR_SIZE-1:0]   ifmap_buffer_start_addr_i,
   input  logic [LEN_W-1:0]           num_lines_i,
   input  logic [MEM_BANDWIDTH*8-1:0] mem_read_data_i,
   input  logic                       mem_valid_i,
   output logic                       mem_read_o,
   output logic [MEM_ADDR_SIZE-1:0]   mem_addr_o,
   input  logic                       mem_req_i,
   output logic [MEM_BANDWIDTH*8-1:0] mem_data_o,
   output logic                       mem_data_valid_o,
   output logic                       mem_ack_o,
   output logic                       busy_o,
   output logic                       done_o
);
   localparam int DATA_W = MEM_BANDWIDTH * 8;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0]         DEPTH_C    = CNT_W'(FIFO_DEPTH);
   localparam logic [MEM_ADDR_SIZE-1:0] LINE_BYTES = MEM_ADDR_SIZE'(MEM_BANDWIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [MEM_ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [LEN_W-1:0]         issued_q, issued_d;
   logic [LEN_W-1:0]         delivered_q, delivered_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [DATA_W-1:0]        fifo_q [FIFO_DEPTH];
   logic                     in_fetch;
   logic                     push;
   logic                     pop;

   // One outstanding read; request held stable until the memory returns it.
   assign in_fetch         = (state_q == S_FETCH);
   assign mem_read_o       = in_fetch && (issued_q < len_q) && (count_q < DEPTH_C);
   assign mem_addr_o       = in_fetch ? cur_addr_q : '0;
   assign mem_data_valid_o = (count_q != '0);
   assign mem_ack_o        = in_fetch && mem_req_i && mem_data_valid_o;
   assign mem_data_o       = fifo_q[rd_ptr_q];
   assign busy_o           = (state_q != S_IDLE);
   assign done_o           = (state_q == S_DONE);
   assign push             = mem_read_o && mem_valid_i;
   assign pop              = mem_ack_o;

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      len_d       = len_q;
      issued_d    = issued_q;
      delivered_d = delivered_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cur_addr_d  = ifmap_buffer_start_addr_i;
               len_d       = num_lines_i;
               issued_d    = '0;
               delivered_d = '0;
               rd_ptr_d    = '0;
               wr_ptr_d    = '0;
               count_d     = '0;
               state_d     = (num_lines_i == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (push) begin
               cur_addr_d = cur_addr_q + LINE_BYTES;
               issued_d   = issued_q + 1'b1;
               wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_d    = rd_ptr_q + 1'b1;
               delivered_d = delivered_q + 1'b1;
            end
            if (push && !pop) begin
               count_d = count_q + 1'b1;
            end else if (pop && !push) begin
               count_d = count_q - 1'b1;
            end
            if (delivered_d == len_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         delivered_q <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         delivered_q <= delivered_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

   // Storage resets to zero so mem_data reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (push) begin
         fifo_q[wr_ptr_q] <= mem_read_data_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifmap_mem_fetch.sv
`default_nettype none
// =============================================================================
// Module : tb_ifmap_mem_fetch
// Directed bench with a latency-configurable memory model and a data scoreboard.
// Rev    : 1.0
// =============================================================================
module tb_ifmap_mem_fetch;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_i;
   logic [31:0]  addr_i;
   logic [15:0]  num_i;
   logic [255:0] mem_read_data_i;
   logic         mem_valid_i;
   logic         mem_read_o;
   logic [31:0]  mem_addr_o;
   logic         mem_req_i;
   logic [255:0] mem_data_o;
   logic         mem_data_valid_o;
   logic         mem_ack_o;
   logic         busy_o;
   logic         done_o;

   ifmap_mem_fetch dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .start_i                   (start_i),
      .ifmap_buffer_start_addr_i (addr_i),
      .num_lines_i               (num_i),
      .mem_read_data_i           (mem_read_data_i),
      .mem_valid_i               (mem_valid_i),
      .mem_read_o                (mem_read_o),
      .mem_addr_o                (mem_addr_o),
      .mem_req_i                 (mem_req_i),
      .mem_data_o                (mem_data_o),
      .mem_data_valid_o          (mem_data_valid_o),
      .mem_ack_o                 (mem_ack_o),
      .busy_o                    (busy_o),
      .done_o                    (done_o)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int cyc = 0;
   int lat = 1;
   int wait_cnt = 0;
   int ack_cnt, done_cnt, last_ack_cyc, done_cyc;
   bit read_seen;
   bit force_valid = 1'b0;
   bit found;
   logic [255:0] sb[$];
   logic [31:0]  addr_log[$];

   function automatic logic [255:0] line_of(input logic [31:0] a);
      return {8{a ^ 32'hC3A5_5A3C}};
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: memory model reacts, acks are scored, then advance to edge+1.
   task automatic cycle();
      if (mem_read_o) begin
         read_seen = 1'b1;
         if (wait_cnt >= lat - 1) begin
            mem_valid_i     = 1'b1;
            mem_read_data_i = line_of(mem_addr_o);
            sb.push_back(line_of(mem_addr_o));
            addr_log.push_back(mem_addr_o);
            wait_cnt = 0;
         end else begin
            mem_valid_i = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_valid_i     = force_valid;
         mem_read_data_i = {8{32'hDEAD_BEEF}};
         wait_cnt        = 0;
      end
      #1;
      if (mem_ack_o) begin
         if (sb.size() == 0) check("ack_without_line", 1, 0);
         else check("ack_data", mem_data_o, sb.pop_front());
         ack_cnt++;
         last_ack_cyc = cyc;
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_start(input logic [31:0] a, input logic [15:0] n);
      ack_cnt = 0; done_cnt = 0; read_seen = 1'b0;
      sb.delete(); addr_log.delete();
      addr_i = a; num_i = n; start_i = 1'b1;
      cycle();
      start_i = 1'b0;
   endtask

   task automatic run_until_done(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         cycle();
         if (done_cnt != 0) break;
      end
      check("done_seen", done_cnt, 1);
   endtask

   initial begin
      rst_n = 1'b0; start_i = 1'b0; addr_i = '0; num_i = '0;
      mem_read_data_i = '0; mem_valid_i = 1'b0; mem_req_i = 1'b1;
      @(posedge clk); #1;
      check("rst_mem_read", mem_read_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_data", mem_data_o, 0);
      check("rst_data_valid", mem_data_valid_o, 0);
      check("rst_ack", mem_ack_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      rst_n = 1'b1;
      cycle();
      check("idle_ack_with_req", mem_ack_o, 0);

      // Basic stream
      lat = 3; mem_req_i = 1'b1;
      do_start(32'h1000, 16'd4);
      check("basic_busy_t1", busy_o, 1);
      check("basic_read_t1", mem_read_o, 1);
      check("basic_addr_t1", mem_addr_o, 32'h1000);
      run_until_done(100);
      check("basic_busy_after", busy_o, 0);
      check("basic_ack_cnt", ack_cnt, 4);
      check("basic_done_timing", done_cyc, last_ack_cyc + 1);
      for (int i = 0; i < 4; i++) check("basic_addr", addr_log[i], 32'h1000 + 32'(i * 32));
      repeat (3) cycle();
      check("basic_done_once", done_cnt, 1);
      check("basic_sb_empty", sb.size(), 0);

      // Backpressure
      lat = 2; mem_req_i = 1'b0;
      do_start(32'h5000, 16'd5);
      repeat (20) cycle();
      check("bp_read_low", mem_read_o, 0);
      check("bp_data_valid", mem_data_valid_o, 1);
      check("bp_returns", addr_log.size(), 2);
      check("bp_no_ack", ack_cnt, 0);
      mem_req_i = 1'b1;
      cycle();
      mem_req_i = 1'b0;
      check("bp_one_ack", ack_cnt, 1);
      check("bp_read_again", mem_read_o, 1);
      check("bp_addr_again", mem_addr_o, 32'h5040);
      mem_req_i = 1'b1;
      run_until_done(100);
      check("bp_ack_cnt", ack_cnt, 5);
      check("bp_done_timing", done_cyc, last_ack_cyc + 1);
      check("bp_last_addr", addr_log[4], 32'h5080);

      // Zero length
      do_start(32'h7000, 16'd0);
      check("zero_done_t1", done_o, 1);
      check("zero_busy_t1", busy_o, 1);
      check("zero_read_t1", mem_read_o, 0);
      cycle();
      check("zero_done_t2", done_o, 0);
      check("zero_busy_t2", busy_o, 0);
      repeat (2) cycle();
      check("zero_no_read", read_seen, 0);
      check("zero_done_once", done_cnt, 1);

      // Address wrap
      lat = 1; mem_req_i = 1'b1;
      do_start(32'hFFFF_FFE0, 16'd2);
      run_until_done(50);
      check("wrap_addr0", addr_log[0], 32'hFFFF_FFE0);
      check("wrap_addr1", addr_log[1], 32'h0000_0000);
      check("wrap_ack_cnt", ack_cnt, 2);

      // Reset mid-fetch
      lat = 2; mem_req_i = 1'b0;
      do_start(32'h2000, 16'd4);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mem_data_valid_o && mem_read_o && (addr_log.size() == 1)) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      check("rstmid_reached", found, 1);
      mem_valid_i = 1'b0;
      mem_req_i = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rstmid_mem_read", mem_read_o, 0);
      check("rstmid_mem_addr", mem_addr_o, 0);
      check("rstmid_mem_data", mem_data_o, 0);
      check("rstmid_data_valid", mem_data_valid_o, 0);
      check("rstmid_ack", mem_ack_o, 0);
      check("rstmid_busy", busy_o, 0);
      check("rstmid_done", done_o, 0);
      sb.delete(); addr_log.delete();
      force_valid = 1'b1;
      cycle();
      rst_n = 1'b1;
      cycle();
      force_valid = 1'b0;
      check("rstmid_late_valid", mem_data_valid_o, 0);
      check("rstmid_late_busy", busy_o, 0);
      lat = 1; mem_req_i = 1'b1;
      do_start(32'h3000, 16'd2);
      check("rstmid_new_addr", mem_addr_o, 32'h3000);
      run_until_done(50);
      check("rstmid_ack_cnt", ack_cnt, 2);
      check("rstmid_addr1", addr_log[1], 32'h3020);

      // Start while busy
      lat = 3; mem_req_i = 1'b1;
      do_start(32'h4000, 16'd3);
      cycle();
      addr_i = 32'h8000; num_i = 16'd7; start_i = 1'b1;
      cycle();
      start_i = 1'b0;
      run_until_done(100);
      check("sbusy_ack_cnt", ack_cnt, 3);
      check("sbusy_reads", addr_log.size(), 3);
      for (int i = 0; i < 3; i++) check("sbusy_addr", addr_log[i], 32'h4000 + 32'(i * 32));
      repeat (3) cycle();
      check("sbusy_idle", busy_o, 0);
      check("sbusy_done_once", done_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound reached, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
